// File: rtl/dice_button_decoder.sv
// +------------------------------------------------------------------------+
// | dice_button_decoder: sync/debounce six dice buttons, queue presses and  |
// | offer them one at a time over valid/ready. Option: DICE_BTN_REPEAT_EN.  |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module dice_button_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES      = 500000,
  parameter int unsigned TEST_DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W                = 20
`ifdef DICE_BTN_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES        = 25000000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       buttonD4,
  input  logic       buttonD6,
  input  logic       buttonD8,
  input  logic       buttonD10,
  input  logic       buttonD12,
  input  logic       buttonD20,
  input  logic       switchTest,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [2:0] req_die,
  output logic [4:0] req_sides,
  output logic       press_dropped
);

  localparam logic [CNT_W-1:0] c_DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TEST_LIM = CNT_W'(TEST_DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  logic [5:0]       w_btn_raw;
  logic [5:0]       btn_s1_q, btn_s2_q;
  logic             test_s1_q, test_s2_q;
  logic [CNT_W-1:0] w_lim;
  logic [5:0]       w_deb;
  logic [5:0]       w_rep;
  logic [5:0]       deb_prev_q;
  logic [5:0]       w_press;
  logic [5:0]       pending_q;
  logic [5:0]       w_clr;
  logic [2:0]       w_sel;
  logic [4:0]       w_sides;
  state_e           state_q;
  logic             req_valid_q;
  logic [2:0]       req_die_q;
  logic [4:0]       req_sides_q;
  logic             drop_q;

  assign w_btn_raw = {buttonD20, buttonD12, buttonD10, buttonD8, buttonD6, buttonD4};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      test_s1_q <= 1'b0;
      test_s2_q <= 1'b0;
    end else begin
      btn_s1_q  <= w_btn_raw;
      btn_s2_q  <= btn_s1_q;
      test_s1_q <= switchTest;
      test_s2_q <= test_s1_q;
    end
  end

  // Limit is re-evaluated every cycle so a mode change applies mid-count.
  assign w_lim = test_s2_q ? c_TEST_LIM : c_DEB_LIM;

  for (genvar g = 0; g < 6; g++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;
    logic             deb_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (btn_s2_q[g] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= w_lim) begin
        cnt_q <= '0;
        deb_q <= btn_s2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign w_deb[g] = deb_q;

`ifdef DICE_BTN_REPEAT_EN
    localparam int unsigned c_REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LIM = c_REP_W'(REPEAT_CYCLES - 1);
    logic [c_REP_W-1:0] rep_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rep_q <= '0;
      end else if (!deb_q || rep_q == c_REP_LIM) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_q + 1'b1;
      end
    end

    assign w_rep[g] = deb_q && (rep_q == c_REP_LIM);
`else
    assign w_rep[g] = 1'b0;
`endif
  end

  assign w_press = (w_deb & ~deb_prev_q) | w_rep;
  assign w_clr   = (state_q == ST_OFFER && req_ready) ? (6'b1 << req_die_q) : 6'b0;

  always_comb begin
    w_sel = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) w_sel = 3'(i);
    end
  end

  always_comb begin
    w_sides = 5'd0;
    case (w_sel)
      3'd0:    w_sides = 5'd4;
      3'd1:    w_sides = 5'd6;
      3'd2:    w_sides = 5'd8;
      3'd3:    w_sides = 5'd10;
      3'd4:    w_sides = 5'd12;
      3'd5:    w_sides = 5'd20;
      default: w_sides = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_q  <= '0;
      pending_q   <= '0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      req_die_q   <= 3'd0;
      req_sides_q <= 5'd0;
    end else begin
      deb_prev_q <= w_deb;
      pending_q  <= (pending_q | w_press) & ~w_clr;
      drop_q     <= |(w_press & pending_q);
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            req_die_q   <= w_sel;
            req_sides_q <= w_sides;
            req_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_GAP;
          end
        end
        // One dead cycle keeps back-to-back offers two cycles apart.
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_valid     = req_valid_q;
  assign req_die       = req_die_q;
  assign req_sides     = req_sides_q;
  assign press_dropped = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_dice_button_decoder.sv
// +------------------------------------------------------------------------+
// | tb_dice_button_decoder: directed vectors for dice_button_decoder.       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_dice_button_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       buttonD4 = 1'b0, buttonD6 = 1'b0, buttonD8 = 1'b0;
  logic       buttonD10 = 1'b0, buttonD12 = 1'b0, buttonD20 = 1'b0;
  logic       switchTest = 1'b0;
  logic       req_ready = 1'b1;
  logic       req_valid;
  logic [2:0] req_die;
  logic [4:0] req_sides;
  logic       press_dropped;

  int n_vec = 0;
  int n_err = 0;
  int n_valid, n_drop, n_hs, hs_die, hs_sides;

  dice_button_decoder #(
    .DEBOUNCE_CYCLES     (8),
    .TEST_DEBOUNCE_CYCLES(4),
    .CNT_W               (20)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .buttonD4     (buttonD4),
    .buttonD6     (buttonD6),
    .buttonD8     (buttonD8),
    .buttonD10    (buttonD10),
    .buttonD12    (buttonD12),
    .buttonD20    (buttonD20),
    .switchTest   (switchTest),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_die      (req_die),
    .req_sides    (req_sides),
    .press_dropped(press_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_valid = 0; n_drop = 0; n_hs = 0; hs_die = -1; hs_sides = -1;
  endtask

  task automatic run_mon(input int n);
    for (int i = 0; i < n; i++) begin
      if (req_valid && req_ready) begin
        n_hs++;
        hs_die   = int'(req_die);
        hs_sides = int'(req_sides);
      end
      tick();
      if (req_valid)     n_valid++;
      if (press_dropped) n_drop++;
    end
  endtask

  initial begin
    int bad;
    tick();
    tick();
    chk_eq("rst_valid", int'(req_valid), 0);
    chk_eq("rst_die", int'(req_die), 0);
    chk_eq("rst_sides", int'(req_sides), 0);
    chk_eq("rst_drop", int'(press_dropped), 0);
    reset_n = 1'b1;
    tick();

    // D6 single press, N=8: offer appears after edge 12
    buttonD6 = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk_eq("d6_early_valid", int'(req_valid), 0);
    tick();
    chk_eq("d6_valid", int'(req_valid), 1);
    chk_eq("d6_die", int'(req_die), 1);
    chk_eq("d6_sides", int'(req_sides), 6);
    tick();
    chk_eq("d6_accepted", int'(req_valid), 0);
    clr_mon();
    run_mon(20);
    chk_eq("d6_no_repeat", n_valid, 0);
    buttonD6 = 1'b0;
    run_mon(15);

    // D8 glitch shorter than debounce
    clr_mon();
    buttonD8 = 1'b1;
    run_mon(5);
    buttonD8 = 1'b0;
    run_mon(20);
    chk_eq("d8_glitch_valid", n_valid, 0);
    chk_eq("d8_glitch_drop", n_drop, 0);

    // D20 + D4 together, ready held low
    req_ready = 1'b0;
    buttonD4  = 1'b1;
    buttonD20 = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk_eq("pair_valid", int'(req_valid), 1);
    chk_eq("pair_die", int'(req_die), 0);
    chk_eq("pair_sides", int'(req_sides), 4);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!req_valid || req_die != 3'd0 || req_sides != 5'd4) bad++;
    end
    chk_eq("pair_d4_stable", bad, 0);
    req_ready = 1'b1;
    tick();
    chk_eq("pair_acc_valid", int'(req_valid), 0);
    tick();
    chk_eq("pair_gap_valid", int'(req_valid), 0);
    tick();
    chk_eq("pair_d20_valid", int'(req_valid), 1);
    chk_eq("pair_d20_die", int'(req_die), 5);
    chk_eq("pair_d20_sides", int'(req_sides), 20);
    tick();
    chk_eq("pair_d20_acc", int'(req_valid), 0);
    buttonD4  = 1'b0;
    buttonD20 = 1'b0;
    run_mon(15);

    // D10 pressed twice while pending: one drop, one roll
    req_ready = 1'b0;
    clr_mon();
    buttonD10 = 1'b1;
    run_mon(14);
    buttonD10 = 1'b0;
    run_mon(14);
    buttonD10 = 1'b1;
    run_mon(14);
    chk_eq("d10_drop_count", n_drop, 1);
    clr_mon();
    req_ready = 1'b1;
    run_mon(12);
    chk_eq("d10_handshakes", n_hs, 1);
    chk_eq("d10_die", hs_die, 3);
    chk_eq("d10_sides", hs_sides, 10);
    buttonD10 = 1'b0;
    run_mon(15);

    // Test mode, N=4: offer appears after edge 8
    switchTest = 1'b1;
    buttonD12  = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk_eq("d12_early_valid", int'(req_valid), 0);
    tick();
    chk_eq("d12_valid", int'(req_valid), 1);
    chk_eq("d12_die", int'(req_die), 4);
    chk_eq("d12_sides", int'(req_sides), 12);
    tick();
    buttonD12 = 1'b0;
    run_mon(10);
    switchTest = 1'b0;
    run_mon(10);

    // Reset during an offer
    req_ready = 1'b0;
    buttonD6  = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk_eq("rst_offer_valid", int'(req_valid), 1);
    reset_n  = 1'b0;
    buttonD6 = 1'b0;
    #1;
    chk_eq("rst_mid_valid", int'(req_valid), 0);
    chk_eq("rst_mid_sides", int'(req_sides), 0);
    tick();
    tick();
    reset_n   = 1'b1;
    req_ready = 1'b1;
    clr_mon();
    run_mon(30);
    chk_eq("rst_no_request", n_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
